// File: rtl/pic_pkg.sv
// Shared types and command codes for the 8259A-compatible interrupt controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pic_pkg;

    // Initialization command word sequencer
    typedef enum logic [1:0] {
        READY     = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } init_state_t;

    // Two-pulse interrupt acknowledge sequencer
    typedef enum logic [1:0] {
        ACK_IDLE = 2'd0,
        ACK1     = 2'd1,
        ACK2     = 2'd2
    } ack_state_t;

    // OCW2 command field d[7:5]
    localparam logic [2:0] NSEOI = 3'b001;
    localparam logic [2:0] SEOI  = 3'b011;

    // Command-word discriminator d[4:3] for a0=0 writes that are not ICW1
    localparam logic [1:0] OCW2_SEL = 2'b00;
    localparam logic [1:0] OCW3_SEL = 2'b01;

    // OCW3 read-select field d[1:0]
    localparam logic [1:0] RSEL_IRR = 2'b10;
    localparam logic [1:0] RSEL_ISR = 2'b11;

endpackage

// File: rtl/pic_prio_resolver.sv
// Fixed-priority resolver: bit 0 is highest priority, bit 7 lowest.
// Latency: purely combinational.
// Backpressure: none.
// Ports: vec (request bits in), vld (any bit set), idx (index of winning bit).
module pic_prio_resolver (
    input  logic [7:0] vec,
    output logic       vld,
    output logic [2:0] idx
);

    always_comb begin
        vld = |vec;
        idx = 3'd0;
        // Scan from lowest priority upward so the last hit is the winner.
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/pic_8259.sv
// 8259A-compatible PIC, PC/XT subset: single, edge-triggered, 8086 vectors.
// Latency: ir->IRR 3 cycles, IRR/IMR/ISR->int_out 1 cycle, rd_n/inta_n->dout_oe 3 cycles.
// Backpressure: none; bus strobes are sampled through synchronizers, no flow control.
// Ports: clk/rst (sync, active high); cs_n/rd_n/wr_n/a0/din register bus;
//        dout/dout_oe read data or vector; ir[7:0] requests; inta_n acknowledge;
//        int_out interrupt request to the CPU.
module pic_8259
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       dout_oe,
    input  logic [7:0] ir,
    input  logic       inta_n,
    output logic       int_out
);

    // ---------------- input synchronizers ----------------
    logic [7:0] ir_s1, ir_s2, ir_d;
    logic       inta_s1, inta_s2, inta_d;
    logic       rd_s1, rd_s2;
    logic       wr_s1, wr_s2, wr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_s1   <= 8'h00;
            ir_s2   <= 8'h00;
            ir_d    <= 8'h00;
            inta_s1 <= 1'b1;
            inta_s2 <= 1'b1;
            inta_d  <= 1'b1;
            rd_s1   <= 1'b1;
            rd_s2   <= 1'b1;
            wr_s1   <= 1'b1;
            wr_s2   <= 1'b1;
            wr_d    <= 1'b1;
        end else begin
            ir_s1   <= ir;
            ir_s2   <= ir_s1;
            ir_d    <= ir_s2;
            inta_s1 <= inta_n;
            inta_s2 <= inta_s1;
            inta_d  <= inta_s2;
            rd_s1   <= rd_n;
            rd_s2   <= rd_s1;
            wr_s1   <= wr_n;
            wr_s2   <= wr_s1;
            wr_d    <= wr_s2;
        end
    end

    logic [7:0] ir_rise;
    logic       inta_fall, inta_rise, wr_rise, rd_act;

    assign ir_rise   = ir_s2 & ~ir_d;
    assign inta_fall = ~inta_s2 & inta_d;
    assign inta_rise = inta_s2 & ~inta_d;
    assign wr_rise   = wr_s2 & ~wr_d;
    assign rd_act    = ~rd_s2 & ~cs_n;

    // ---------------- write capture ----------------
    // wr_pend remembers that this strobe was actually addressed to us, so a
    // wr_n pulse with cs_n high never commits stale data.
    logic       wr_a0, wr_pend;
    logic [7:0] wr_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_a0   <= 1'b0;
            wr_dat  <= 8'h00;
            wr_pend <= 1'b0;
        end else if (!wr_s2 && !cs_n) begin
            wr_a0   <= a0;
            wr_dat  <= din;
            wr_pend <= 1'b1;
        end else if (wr_rise) begin
            wr_pend <= 1'b0;
        end
    end

    // ---------------- register state ----------------
    logic [7:0] irr, isr, imr;
    logic [4:0] base;
    logic       aeoi, ic4, sngl, rsel_isr, initialized;

    init_state_t init_state, init_nxt;
    ack_state_t  ack_state, ack_nxt;
    logic [2:0]  ack_lvl, lvl_nxt;
    logic        ack_vec, vec_nxt;

    logic       commit, icw1, ready_cmd, ocw1, ocw2, ocw3, icw2_wr, icw4_wr;
    logic       init_done;

    assign commit    = wr_rise & wr_pend;
    assign icw1      = commit & ~wr_a0 & wr_dat[4];
    assign ready_cmd = commit & ~icw1 & (init_state == READY);
    assign ocw1      = ready_cmd & wr_a0;
    assign ocw2      = ready_cmd & ~wr_a0 & (wr_dat[4:3] == OCW2_SEL);
    assign ocw3      = ready_cmd & ~wr_a0 & (wr_dat[4:3] == OCW3_SEL);
    assign icw2_wr   = commit & wr_a0 & (init_state == WAIT_ICW2);
    assign icw4_wr   = commit & wr_a0 & (init_state == WAIT_ICW4);

    // ---------------- priority resolution ----------------
    logic       req_vld, isr_vld;
    logic [2:0] req_idx, isr_idx;

    pic_prio_resolver u_req_prio (
        .vec (irr & ~imr),
        .vld (req_vld),
        .idx (req_idx)
    );

    pic_prio_resolver u_isr_prio (
        .vec (isr),
        .vld (isr_vld),
        .idx (isr_idx)
    );

    // ---------------- init FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            init_state <= READY;
        end else begin
            init_state <= init_nxt;
        end
    end

    always_comb begin
        init_nxt  = init_state;
        init_done = 1'b0;
        if (icw1) begin
            init_nxt = WAIT_ICW2;
        end else if (commit && wr_a0) begin
            case (init_state)
                WAIT_ICW2: begin
                    if (!sngl) begin
                        init_nxt = WAIT_ICW3;
                    end else if (ic4) begin
                        init_nxt = WAIT_ICW4;
                    end else begin
                        init_nxt  = READY;
                        init_done = 1'b1;
                    end
                end
                WAIT_ICW3: begin
                    if (ic4) begin
                        init_nxt = WAIT_ICW4;
                    end else begin
                        init_nxt  = READY;
                        init_done = 1'b1;
                    end
                end
                WAIT_ICW4: begin
                    init_nxt  = READY;
                    init_done = 1'b1;
                end
                default: init_nxt = init_state;
            endcase
        end
    end

    // ---------------- INTA FSM ----------------
    // ack_vec marks the second pulse's low phase, while the vector is on dout.
    logic ack_take, ack_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_state <= ACK_IDLE;
            ack_lvl   <= 3'd0;
            ack_vec   <= 1'b0;
        end else begin
            ack_state <= ack_nxt;
            ack_lvl   <= lvl_nxt;
            ack_vec   <= vec_nxt;
        end
    end

    always_comb begin
        ack_nxt  = ack_state;
        lvl_nxt  = ack_lvl;
        vec_nxt  = ack_vec;
        ack_take = 1'b0;
        ack_done = 1'b0;
        case (ack_state)
            ACK_IDLE: begin
                if (inta_fall) begin
                    ack_nxt  = ACK1;
                    ack_take = 1'b1;
                    // Nothing pending: report spurious level 7.
                    lvl_nxt  = req_vld ? req_idx : 3'd7;
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    ack_nxt = ACK2;
                end
            end
            ACK2: begin
                if (inta_fall) begin
                    vec_nxt = 1'b1;
                end else if (inta_rise && ack_vec) begin
                    ack_nxt  = ACK_IDLE;
                    vec_nxt  = 1'b0;
                    ack_done = 1'b1;
                end
            end
            default: ack_nxt = ACK_IDLE;
        endcase
    end

    // ---------------- IRR / ISR next state ----------------
    // Ordering encodes the collision rules: clears first, then sets, and a
    // committed ICW1 overrides everything.
    logic [7:0] irr_nxt, isr_nxt;

    always_comb begin
        irr_nxt = irr;
        if (ack_take && req_vld) begin
            irr_nxt[req_idx] = 1'b0;
        end
        irr_nxt = irr_nxt | ir_rise;
        if (icw1) begin
            irr_nxt = 8'h00;
        end
    end

    always_comb begin
        isr_nxt = isr;
        if (ocw2 && wr_dat[7:5] == NSEOI && isr_vld) begin
            isr_nxt[isr_idx] = 1'b0;
        end
        if (ocw2 && wr_dat[7:5] == SEOI) begin
            isr_nxt[wr_dat[2:0]] = 1'b0;
        end
        if (ack_done && aeoi) begin
            isr_nxt[ack_lvl] = 1'b0;
        end
        if (ack_take && req_vld) begin
            isr_nxt[req_idx] = 1'b1;
        end
        if (icw1) begin
            isr_nxt = 8'h00;
        end
    end

    // ---------------- outputs ----------------
    logic       int_nxt, oe_nxt;
    logic [7:0] dout_nxt, rd_data;

    assign rd_data = a0 ? imr : (rsel_isr ? isr : irr);

    always_comb begin
        // int_out is forced low for the whole acknowledge sequence.
        int_nxt  = initialized && (ack_nxt == ACK_IDLE) && req_vld &&
                   (!isr_vld || (req_idx < isr_idx));
        oe_nxt   = vec_nxt | rd_act;
        dout_nxt = 8'h00;
        if (vec_nxt) begin
            dout_nxt = {base, lvl_nxt};
        end else if (rd_act) begin
            dout_nxt = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irr         <= 8'h00;
            isr         <= 8'h00;
            imr         <= 8'hFF;
            base        <= 5'd0;
            aeoi        <= 1'b0;
            ic4         <= 1'b0;
            sngl        <= 1'b0;
            rsel_isr    <= 1'b0;
            initialized <= 1'b0;
            int_out     <= 1'b0;
            dout        <= 8'h00;
            dout_oe     <= 1'b0;
        end else begin
            irr         <= irr_nxt;
            isr         <= isr_nxt;
            int_out     <= int_nxt;
            dout        <= dout_nxt;
            dout_oe     <= oe_nxt;
            initialized <= initialized | init_done;
            if (icw1) begin
                imr      <= 8'h00;
                ic4      <= wr_dat[0];
                sngl     <= wr_dat[1];
                rsel_isr <= 1'b0;
            end
            if (icw2_wr) begin
                base <= wr_dat[7:3];
            end
            if (icw4_wr) begin
                aeoi <= wr_dat[1];
            end
            if (ocw1) begin
                imr <= wr_dat;
            end
            if (ocw3) begin
                if (wr_dat[1:0] == RSEL_IRR) begin
                    rsel_isr <= 1'b0;
                end else if (wr_dat[1:0] == RSEL_ISR) begin
                    rsel_isr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/pic_8259.md
# pic_8259

Single-chip 8259A-compatible programmable interrupt controller, reduced to the PC/XT configuration (single, edge-triggered, 8086 mode). Sits directly downstream of the `intel8253` timer: PIT OUT0 drives `ir[0]` (IRQ0, system tick), and the remaining `ir` lines take keyboard, floppy and other device requests. It resolves priority, raises `int_out` to the CPU, and returns the interrupt vector on the two-pulse INTA bus cycle.

## Interface
- No parameters; the PC/XT mapping is fixed.
- `clk` in 1 — system clock; all state changes on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `cs_n` in 1 — chip select, active low.
- `rd_n` in 1 — register read strobe, active low.
- `wr_n` in 1 — register write strobe, active low.
- `a0` in 1 — register address bit.
- `din` in 8 — write data.
- `dout` out 8 — read data or vector.
- `dout_oe` out 1 — `dout` valid; drives the external tristate.
- `ir` in 8 — asynchronous interrupt requests. `ir[0]` = PIT OUT0.
- `inta_n` in 1 — interrupt acknowledge, active low.
- `int_out` out 1 — interrupt request to the CPU, active high.

## Operation
- **Input sync:** `ir`, `inta_n`, `rd_n` and `wr_n` each pass through a 2-flop synchronizer.
- **Bus write:**
  - Latch `a0`/`din` on every cycle where the synced `wr_n` is low and `cs_n` is low.
  - Commit the write on the synced `wr_n` 0→1 edge.
- **Init FSM:** states `READY`, `WAIT_ICW2`, `WAIT_ICW3`, `WAIT_ICW4`.
  - ICW1 (`a0`=0, `d4`=1) is accepted in any state. It sets IMR=0, ISR=0, IRR=0 and read-select=IRR, stores IC4=`d0` and SNGL=`d1`, then goes to `WAIT_ICW2`.
  - ICW2 (`a0`=1) stores base=`d[7:3]`. Next state is `WAIT_ICW3` if SNGL=0; otherwise `WAIT_ICW4` if IC4=1; otherwise `READY`.
  - ICW3 is discarded. Next state is `WAIT_ICW4` if IC4=1, else `READY`.
  - ICW4 stores AEOI=`d1`, then goes to `READY`.
- **Operation commands (`READY` only):**
  - OCW1 (`a0`=1) writes IMR.
  - OCW2 (`a0`=0, `d4:3`=00):
    - `d7:5`=001 is a non-specific EOI: clear the highest-priority set ISR bit.
    - `d7:5`=011 is a specific EOI: clear ISR[`d2:0`].
    - All other codes are ignored.
  - OCW3 (`a0`=0, `d4:3`=01): `d1:0`=10 selects IRR for reads, 11 selects ISR; other values leave the selection unchanged.
- **Bus read:** `a0`=0 returns IRR or ISR, per read-select. `a0`=1 returns IMR.
- **Requests:**
  - A synced `ir[i]` 0→1 edge sets IRR[i].
  - Priority is fixed: IR0 highest, IR7 lowest.
  - `int_out` = 1 when the highest bit of IRR & ~IMR has higher priority than the highest ISR bit, or ISR=0. It is also gated to 0 until the first ICW sequence completes.
- **INTA FSM:** states `ACK_IDLE`, `ACK1`, `ACK2`.
  - On the first synced `inta_n` fall, enter `ACK1` and freeze the winner level L: set ISR[L], clear IRR[L].
  - If nothing is pending at that point, L=7 is spurious: ISR is not set.
  - On `inta_n` rise, go to `ACK2`. On the second fall, drive `dout`={base,L} with `dout_oe`=1 until `inta_n` rises, then return to `ACK_IDLE`.
  - If AEOI=1, clear ISR[L] when `inta_n` rises on the second pulse.
  - `int_out` is forced to 0 while in `ACK1`/`ACK2`.

## Timing
- **Reset values:**
  - `int_out`=0, `dout`=0x00, `dout_oe`=0.
  - IMR=0xFF, IRR=0, ISR=0, base=0, AEOI=0.
  - Init FSM=`READY` but not yet initialized; INTA FSM=`ACK_IDLE`.
- **Latencies:**
  - `ir` rise → IRR bit set: 3 cycles.
  - `int_out` is registered and updates 1 cycle after IRR/IMR/ISR change.
  - Read: `dout_oe` rises 3 cycles after `rd_n` falls (sync + 1) and falls 3 cycles after `rd_n` rises.
  - Vector output follows the same latency, relative to the second `inta_n` edges.
- **Simultaneous events:**
  - An `ir` edge in the same cycle that INTA clears the same IRR bit: the set wins.
  - ICW1 during `ACK1`/`ACK2`: register reset applies, but the INTA FSM completes with L unchanged.
  - EOI in the same cycle as an ISR set: apply both; the set wins on the same bit.
- **Reset mid-operation:** `rst` during any INTA or ICW phase returns both FSMs to reset state the next cycle, with `dout_oe`=0.

## Structure
- **Package `pic_pkg`:**
  - Init FSM and INTA FSM state enums.
  - OCW2 command codes (`NSEOI`=3'b001, `SEOI`=3'b011).
  - OCW3 read-select codes.
- **Sub-module `pic_prio_resolver`:** combinational; 8-bit vector in → valid + 3-bit highest-priority index. Instantiate it twice: for IRR & ~IMR, and for ISR.

## Test plan
- **Init + tick:** ICW1=0x13, ICW2=0x08, ICW4=0x01, OCW1=0xFE; pulse `ir[0]` → `int_out`=1; two INTA pulses → vector 0x08, ISR=0x01, `int_out`=0.
- **Priority/nesting:** IMR=0x00; raise `ir[3]` then `ir[1]` with ISR[3] set → `int_out` reasserts; INTA → vector base+1; non-specific EOI (0x20) clears ISR[1] only.
- **Masking:** IMR=0xFF, pulse `ir[2]` → IRR=0x04, `int_out`=0; OCW1=0x00 → `int_out`=1 two cycles later.
- **Spurious:** `int_out` high, drop the request by masking before the first INTA → vector base+7, ISR unchanged.
- **AEOI and readback:** ICW4=0x03; after the full INTA, ISR=0. OCW3=0x0B then read → ISR; OCW3=0x0A then read → IRR; `a0`=1 read → IMR.
- **Reset mid-INTA:** assert `rst` between the two INTA pulses → `dout_oe`=0, IMR=0xFF, and no vector is driven on the following pulse.
